unidade_busca: RTL and testbench
================================

UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 The block SHALL have parameter ULTIMO_ENDERECO, default 1024, meaning the highest valid instruction word address.
REQ-003 The block SHALL have parameter OPCODE_HALT, default 6'b111111, meaning the opcode in bits [31:26] that stops fetching.
REQ-004 The block SHALL have port endereco  out  32  word address driven to the instruction memory.
REQ-005 The block SHALL have port instrucao  in  32  word returned combinationally by the instruction memory for endereco.
REQ-006 The block SHALL have port desvio  in  1  branch/jump taken, a one-cycle pulse from the execute stage.
REQ-007 The block SHALL have port alvo_desvio  in  32  word address of the branch target, valid when desvio=1.
REQ-008 The block SHALL have port consumidor_pronto  in  1  decode stage accepts the output this cycle.
REQ-009 The block SHALL have ports instrucao_saida  out  32 and pc_saida  out  32  for the registered instruction and its address.
REQ-010 The block SHALL have port valida  out  1  meaning instrucao_saida/pc_saida hold a live instruction.
REQ-011 The block SHALL have ports erro_endereco  out  1 (sticky out-of-range target flag) and contador_instrucoes  out  32 (count of accepted instructions).

Function
REQ-012 The block SHALL use word addressing: the sequential next address is endereco+1, with endereco=ULTIMO_ENDERECO wrapping to 0.
REQ-013 The block SHALL drive endereco directly from the PC register, so memory latency is zero cycles and fetch-to-valida latency is one cycle.
REQ-014 The output register SHALL load {instrucao, endereco} and set valida=1 when state=BUSCANDO and (valida=0 or consumidor_pronto=1); the PC SHALL advance only on such a load.
REQ-015 When valida=1 and consumidor_pronto=0, the block SHALL hold PC, instrucao_saida, pc_saida and valida unchanged (stall).
REQ-016 A handshake (valida=1 and consumidor_pronto=1) SHALL increment contador_instrucoes by 1 modulo 2^32.
REQ-017 The FSM SHALL have two states: BUSCANDO (fetching) and PARADO (halted).
REQ-018 BUSCANDO SHALL go to PARADO when the loaded instruction has bits [31:26]=OPCODE_HALT; the halt word is still presented with valida=1 and the PC is not advanced past it.
REQ-019 In PARADO the block SHALL perform no loads; valida SHALL clear after the halt word is accepted and stay 0.
REQ-020 desvio=1 SHALL, in any state, have priority over stall, load and halt: next cycle PC=alvo_desvio, valida=0 (flush), state=BUSCANDO; a handshake in the same cycle still counts.
REQ-021 If alvo_desvio > ULTIMO_ENDERECO, the block SHALL load PC=0 and set erro_endereco=1, which stays set until reset.
REQ-022 The block SHALL never load more than one instruction per cycle; no combinational path SHALL run from consumidor_pronto to endereco.

Reset
REQ-023 On reset the block SHALL set PC=0, endereco=0, valida=0, instrucao_saida=0, pc_saida=0, erro_endereco=0, contador_instrucoes=0, state=BUSCANDO.
REQ-024 Reset SHALL override desvio and any in-flight handshake; the first load after reset SHALL fetch address 0.

Structure
REQ-025 A shared processor package SHALL hold the state enum (BUSCANDO, PARADO), the opcode field position [31:26], OPCODE_HALT and ULTIMO_ENDERECO.
REQ-026 One sub-module, registrador_busca (output register with valid/ready hold logic), is natural; the PC, FSM and counter stay in unidade_busca.

Verification
REQ-027 Reset release, consumidor_pronto=1, ROM[0..2]=nonhalt -> pc_saida 0,1,2 on consecutive cycles; valida=1 from the second cycle; contador_instrucoes=3 after three handshakes.
REQ-028 consumidor_pronto=0 for 3 cycles at pc_saida=5 -> outputs and endereco=6 hold for 3 cycles; no count increment; resume at 6.
REQ-029 desvio=1, alvo_desvio=100, during a stall -> next cycle valida=0, endereco=100; the following cycle pc_saida=100.
REQ-030 ROM[7] opcode 111111 -> pc_saida=7 presented, state PARADO, endereco stays 7, valida=0 after acceptance; a later desvio to 20 resumes fetch at 20.
REQ-031 Sequential fetch at 1024 -> next endereco=0; desvio with alvo_desvio=2000 -> endereco=0, erro_endereco=1 until reset.
REQ-032 Reset asserted mid-stall with valida=1 -> next cycle all outputs are at reset values; fetch restarts at 0.

Source files
------------

// File: rtl/unidade_busca_pkg.sv
// Shared processor definitions for the instruction fetch unit: FSM states,
// opcode field position and the default address/halt parameters.
package unidade_busca_pkg;

    typedef enum logic {
        BUSCANDO = 1'b0,
        PARADO   = 1'b1
    } estado_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [5:0]  OPCODE_HALT_PADRAO     = 6'b111111;
    localparam int unsigned ULTIMO_ENDERECO_PADRAO = 1024;

endpackage

// File: rtl/unidade_busca_registrador.sv
// Fetch output register: holds one instruction and its address with a
// valid/ready handshake towards the decode stage.
module registrador_busca (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        carregar,
    input  logic        consumidor_pronto,
    input  logic [31:0] dado_instrucao,
    input  logic [31:0] dado_pc,
    output logic [31:0] instrucao_saida,
    output logic [31:0] pc_saida,
    output logic        valida
);

    logic [31:0] instrucao_d, instrucao_q;
    logic [31:0] pc_d, pc_q;
    logic        valida_d, valida_q;

    always_comb begin
        // NOTE: every output gets its hold value first so no path leaves it unassigned (no latch).
        instrucao_d = instrucao_q;
        pc_d        = pc_q;
        valida_d    = valida_q;
        if (flush) begin
            valida_d = 1'b0;
        end else if (carregar) begin
            instrucao_d = dado_instrucao;
            pc_d        = dado_pc;
            valida_d    = 1'b1;
        end else if (valida_q && consumidor_pronto) begin
            valida_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            instrucao_q <= '0;
            pc_q        <= '0;
            valida_q    <= 1'b0;
        end else begin
            instrucao_q <= instrucao_d;
            pc_q        <= pc_d;
            valida_q    <= valida_d;
        end
    end

    assign instrucao_saida = instrucao_q;
    assign pc_saida        = pc_q;
    assign valida          = valida_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: PC register, fetch/halt FSM, branch redirect with
// out-of-range detection, and a count of instructions handed to decode.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int unsigned ULTIMO_ENDERECO = ULTIMO_ENDERECO_PADRAO,
    parameter logic [5:0]  OPCODE_HALT     = OPCODE_HALT_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] endereco,
    input  logic [31:0] instrucao,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    input  logic        consumidor_pronto,
    output logic [31:0] instrucao_saida,
    output logic [31:0] pc_saida,
    output logic        valida,
    output logic        erro_endereco,
    output logic [31:0] contador_instrucoes
);

    localparam logic [31:0] ULTIMO = 32'(ULTIMO_ENDERECO);

    estado_t     estado_d, estado_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] contador_d, contador_q;
    logic        erro_d, erro_q;

    logic        carregar;
    logic        handshake;
    logic        eh_halt;
    logic        alvo_invalido;
    logic [31:0] pc_seguinte;

    always_comb begin
        pc_seguinte   = (pc_q == ULTIMO) ? '0 : pc_q + 32'd1;
        alvo_invalido = (alvo_desvio > ULTIMO);
        eh_halt       = (instrucao[OPCODE_MSB:OPCODE_LSB] == OPCODE_HALT);
        handshake     = valida && consumidor_pronto;
        // A taken branch suppresses the load: the slot is flushed instead.
        carregar      = !desvio && (estado_q == BUSCANDO) && (!valida || consumidor_pronto);

        estado_d   = estado_q;
        pc_d       = pc_q;
        erro_d     = erro_q;
        contador_d = contador_q;

        if (desvio) begin
            estado_d = BUSCANDO;
            pc_d     = alvo_invalido ? '0 : alvo_desvio;
            if (alvo_invalido) begin
                erro_d = 1'b1;
            end
        end else if (carregar) begin
            // The halt word is presented but the PC stays on it.
            if (eh_halt) begin
                estado_d = PARADO;
            end else begin
                pc_d = pc_seguinte;
            end
        end

        if (handshake) begin
            contador_d = contador_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= BUSCANDO;
            pc_q       <= '0;
            erro_q     <= 1'b0;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            erro_q     <= erro_d;
            contador_q <= contador_d;
        end
    end

    registrador_busca u_registrador (
        .clock             (clock),
        .reset             (reset),
        .flush             (desvio),
        .carregar          (carregar),
        .consumidor_pronto (consumidor_pronto),
        .dado_instrucao    (instrucao),
        .dado_pc           (pc_q),
        .instrucao_saida   (instrucao_saida),
        .pc_saida          (pc_saida),
        .valida            (valida)
    );

    assign endereco            = pc_q;
    assign erro_endereco       = erro_q;
    assign contador_instrucoes = contador_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed scenarios plus random
// stimulus, checked by a program-stream scoreboard and a handshake counter model.
module tb_unidade_busca;

    localparam int          ULT    = 1024;
    localparam logic [31:0] ULT32  = 32'd1024;
    localparam logic [5:0]  HALT   = 6'b111111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] endereco;
    logic [31:0] instrucao;
    logic        desvio = 1'b0;
    logic [31:0] alvo_desvio = '0;
    logic        consumidor_pronto = 1'b1;
    logic [31:0] instrucao_saida;
    logic [31:0] pc_saida;
    logic        valida;
    logic        erro_endereco;
    logic [31:0] contador_instrucoes;

    logic [31:0] rom [0:ULT];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    item_t fila[$];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign instrucao = (endereco <= ULT32) ? rom[endereco[10:0]] : 32'hDEAD_BEEF;

    unidade_busca dut (
        .clock               (clock),
        .reset               (reset),
        .endereco            (endereco),
        .instrucao           (instrucao),
        .desvio              (desvio),
        .alvo_desvio         (alvo_desvio),
        .consumidor_pronto   (consumidor_pronto),
        .instrucao_saida     (instrucao_saida),
        .pc_saida            (pc_saida),
        .valida              (valida),
        .erro_endereco       (erro_endereco),
        .contador_instrucoes (contador_instrucoes)
    );

    task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        total++;
        if (obtido !== esperado) begin
            bad++;
            $display("FAIL %s: obtido=%0h esperado=%0h t=%0t", nome, obtido, esperado, $time);
        end
    endtask

    function automatic logic [31:0] palavra(input bit halt_ok);
        logic [31:0] w;
        w = $urandom;
        if (halt_ok && $urandom_range(0, 39) == 0) begin
            w[31:26] = HALT;
        end else if (w[31:26] == HALT) begin
            w[31:26] = 6'h00;
        end
        return w;
    endfunction

    // Expected program stream from a start address: sequential words with
    // wrap after the last address, ending at (and including) a halt word.
    task automatic recarregar(input logic [31:0] inicio);
        logic [31:0] a;
        a = inicio;
        fila.delete();
        for (int n = 0; n < ULT + 2; n++) begin
            fila.push_back('{pc: a, instr: rom[a]});
            if (rom[a][31:26] == HALT) break;
            a = (a == ULT32) ? 32'd0 : a + 32'd1;
        end
    endtask

    // Monitor / scoreboard
    logic        prev_reset = 1'b1;
    logic        prev_desvio = 1'b0;
    logic        prev_valida = 1'b0;
    logic        prev_pronto = 1'b0;
    logic [31:0] prev_alvo = '0;
    logic [31:0] prev_pc_saida = '0;
    logic [31:0] prev_instr = '0;
    logic [31:0] prev_endereco = '0;
    logic        erro_m = 1'b0;
    logic [31:0] cnt_m = '0;

    initial begin
        item_t it;
        forever begin
            @(negedge clock);
            if (prev_reset) begin
                check("reset_valida", 32'(valida), 32'd0);
                check("reset_pc_saida", pc_saida, 32'd0);
                check("reset_instrucao_saida", instrucao_saida, 32'd0);
                check("reset_endereco", endereco, 32'd0);
            end else if (prev_desvio) begin
                check("flush_valida", 32'(valida), 32'd0);
                check("desvio_endereco", endereco, (prev_alvo > ULT32) ? 32'd0 : prev_alvo);
            end else if (prev_valida && !prev_pronto) begin
                check("stall_valida", 32'(valida), 32'd1);
                check("stall_pc_saida", pc_saida, prev_pc_saida);
                check("stall_instrucao", instrucao_saida, prev_instr);
                check("stall_endereco", endereco, prev_endereco);
            end else if (fila.size() != 0) begin
                check("sem_bolha_valida", 32'(valida), 32'd1);
            end
            check("erro_endereco", 32'(erro_endereco), 32'(erro_m));
            check("contador", contador_instrucoes, cnt_m);

            if (!reset && valida && consumidor_pronto) begin
                if (fila.size() == 0) begin
                    check("handshake_extra_valida", 32'(valida), 32'd0);
                end else begin
                    it = fila.pop_front();
                    check("fluxo_pc_saida", pc_saida, it.pc);
                    check("fluxo_instrucao", instrucao_saida, it.instr);
                end
                cnt_m = cnt_m + 32'd1;
            end

            if (reset) begin
                erro_m = 1'b0;
                cnt_m  = '0;
                recarregar(32'd0);
            end else if (desvio) begin
                if (alvo_desvio > ULT32) erro_m = 1'b1;
                recarregar((alvo_desvio > ULT32) ? 32'd0 : alvo_desvio);
            end

            prev_reset    = reset;
            prev_desvio   = desvio;
            prev_valida   = valida;
            prev_pronto   = consumidor_pronto;
            prev_alvo     = alvo_desvio;
            prev_pc_saida = pc_saida;
            prev_instr    = instrucao_saida;
            prev_endereco = endereco;
        end
    end

    // Stimulus helpers: inputs change only #1 after a rising edge.
    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic pulso_desvio(input logic [31:0] alvo);
        desvio      = 1'b1;
        alvo_desvio = alvo;
        ciclo();
        desvio = 1'b0;
    endtask

    task automatic esperar_pc(input logic [31:0] alvo, input string nome);
        bit achou;
        achou = 1'b0;
        for (int i = 0; i < 40 && !achou; i++) begin
            ciclo();
            if (valida && pc_saida == alvo) achou = 1'b1;
        end
        check(nome, 32'(achou), 32'd1);
    endtask

    initial begin
        for (int i = 0; i <= ULT; i++) rom[i] = palavra(1'b0);
        rom[7] = {HALT, 26'h0123456};

        ciclo();
        ciclo();
        reset = 1'b0;

        // Sequential start, then a 3-cycle stall at pc_saida=5.
        esperar_pc(32'd5, "espera_pc5");
        consumidor_pronto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ciclo();
            check("dir_stall_endereco", endereco, 32'd6);
            check("dir_stall_pc_saida", pc_saida, 32'd5);
        end
        consumidor_pronto = 1'b1;
        ciclo();
        check("dir_retoma_pc6", pc_saida, 32'd6);

        // Halt at 7, then a branch resumes fetch at 20.
        esperar_pc(32'd7, "espera_halt7");
        ciclo();
        ciclo();
        ciclo();
        check("dir_parado_valida", 32'(valida), 32'd0);
        check("dir_parado_endereco", endereco, 32'd7);
        pulso_desvio(32'd20);
        esperar_pc(32'd20, "espera_pc20");

        // Branch to 100 during a stall.
        consumidor_pronto = 1'b0;
        ciclo();
        pulso_desvio(32'd100);
        check("dir_flush_valida", 32'(valida), 32'd0);
        check("dir_flush_endereco", endereco, 32'd100);
        consumidor_pronto = 1'b1;
        ciclo();
        check("dir_pc100", pc_saida, 32'd100);

        // Wrap at the last address, then an out-of-range target.
        pulso_desvio(32'd1022);
        esperar_pc(32'd1024, "espera_pc1024");
        ciclo();
        check("dir_wrap_pc0", pc_saida, 32'd0);
        pulso_desvio(32'd2000);
        check("dir_erro_endereco", endereco, 32'd0);
        check("dir_erro_flag", 32'(erro_endereco), 32'd1);

        // Reset in the middle of a stall.
        consumidor_pronto = 1'b0;
        ciclo();
        ciclo();
        check("dir_stall_pre_reset", 32'(valida), 32'd1);
        check("dir_erro_persiste", 32'(erro_endereco), 32'd1);
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        consumidor_pronto = 1'b1;
        check("dir_reset_erro", 32'(erro_endereco), 32'd0);
        check("dir_reset_contador", contador_instrucoes, 32'd0);
        esperar_pc(32'd0, "espera_pc0_pos_reset");

        // Random phase with halts sprinkled through memory.
        reset = 1'b1;
        for (int i = 0; i <= ULT; i++) rom[i] = palavra(1'b1);
        ciclo();
        reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            consumidor_pronto = ($urandom_range(0, 3) != 0);
            desvio            = ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      alvo_desvio = $urandom_range(1025, 5000);
            else if (r == 1) alvo_desvio = $urandom_range(1018, 1024);
            else             alvo_desvio = $urandom_range(0, 1024);
            reset = ($urandom_range(0, 599) == 0);
            ciclo();
        end
        reset             = 1'b0;
        desvio            = 1'b0;
        consumidor_pronto = 1'b1;
        ciclo();
        ciclo();
        ciclo();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
